dcache_backing_mem: RTL

Memory-side responder for the core's data-memory port: serves aligned cache-line reads after a fixed latency and commits byte/halfword/word stores immediately. Sits outside the core, directly on `mem_rd_*` / `mem_wr_*`, and acts as the backing store behind the MEM-stage cache. It adds `mem_rd_valid`, `mem_busy` and `mem_err`, which the cache miss logic uses in place of a fixed wait.

---
 rtl/dcache_backing_mem_pkg.sv | 30 +++
 rtl/dcache_backing_mem_wr_lane_decode.sv | 41 ++++
 rtl/dcache_backing_mem.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dcache_backing_mem_pkg.sv
// Shared definitions for the data-cache backing memory: store-size encodings,
// read FSM states and address-field width helpers.
package dcache_backing_mem_pkg;

  typedef enum logic [1:0] {
    SEL_BYTE = 2'b00,
    SEL_HALF = 2'b01,
    SEL_WORD = 2'b10,
    SEL_RSVD = 2'b11
  } wr_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rd_state_e;

  // Fill bit for the line bus after reset.
  localparam logic LINE_RST_BIT = 1'b0;

  // Byte-offset bits within a cache line.
  function automatic int unsigned line_off_w(input int unsigned line_words);
    return $clog2(line_words * 4);
  endfunction

  // Word-index bits into the array.
  function automatic int unsigned word_idx_w(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dcache_backing_mem_wr_lane_decode.sv
// Store-size decode: byte-lane enables, lane-replicated store data and
// a misalignment flag for halfword/word stores.
module wr_lane_decode
  import dcache_backing_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] data,
  output logic [3:0]        lane_en,
  output logic [DATA_W-1:0] lane_data,
  output logic              misalign
);

  localparam int unsigned LANE_W = DATA_W / 4;

  always_comb begin
    lane_en   = '0;
    lane_data = '0;
    misalign  = 1'b0;
    case (sel)
      SEL_BYTE: begin
        lane_en   = 4'b0001 << addr_lo;
        lane_data = {4{data[LANE_W-1:0]}};
      end
      SEL_HALF: begin
        lane_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{data[2*LANE_W-1:0]}};
        misalign  = addr_lo[0];
      end
      SEL_WORD: begin
        lane_en   = '1;
        lane_data = data;
        misalign  = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dcache_backing_mem.sv
// Backing store behind the MEM-stage cache: fixed-latency aligned line reads
// with same-edge store forwarding, and immediate byte/half/word stores.
module dcache_backing_mem
  import dcache_backing_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned READ_LAT    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_rd_en,
  input  logic [ADDR_W-1:0]            mem_rd_addr,
  output logic [LINE_WORDS*DATA_W-1:0] mem_rd_data,
  output logic                         mem_rd_valid,
  output logic                         mem_busy,
  input  logic                         mem_wr_en,
  input  logic [ADDR_W-1:0]            mem_wr_addr,
  input  logic [DATA_W-1:0]            mem_wr_data,
  input  logic [1:0]                   mem_wr_sel,
  output logic                         mem_err
);

  localparam int unsigned OFF_W  = line_off_w(LINE_WORDS);
  localparam int unsigned WIDX_W = word_idx_w(DEPTH_WORDS);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W;
  localparam int unsigned LIDX_W = WIDX_W + 2 - OFF_W;
  localparam int unsigned LINE_W = LINE_WORDS * DATA_W;
  localparam int unsigned LANE_W = DATA_W / 4;
  localparam int unsigned CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  rd_state_e          state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [TAG_W-1:0]   rd_tag, rd_tag_in, ret_tag;
  logic               accept, ret_fire, ret_in_range;
  logic               rd_addr_unused;

  logic [3:0]         lane_en;
  logic [DATA_W-1:0]  lane_data;
  logic               misalign, wr_in_range, wr_bad, wr_commit, wr_drop;
  logic [WIDX_W-1:0]  wr_idx;

  logic [LANE_W-1:0]  ram [4][DEPTH_WORDS];
  logic [LINE_W-1:0]  line_merged;

  assign rd_tag_in      = mem_rd_addr[ADDR_W-1:OFF_W];
  assign rd_addr_unused = ^mem_rd_addr[OFF_W-1:0];
  assign mem_busy       = (state == ST_BUSY);

  wr_lane_decode #(.DATA_W(DATA_W)) u_wr_lane_decode (
    .sel      (mem_wr_sel),
    .addr_lo  (mem_wr_addr[1:0]),
    .data     (mem_wr_data),
    .lane_en  (lane_en),
    .lane_data(lane_data),
    .misalign (misalign)
  );

  assign wr_in_range = ~|mem_wr_addr[ADDR_W-1:WIDX_W+2];
  assign wr_bad      = misalign | (mem_wr_sel == SEL_RSVD) | ~wr_in_range;
  assign wr_commit   = mem_wr_en & ~wr_bad & ~rst;
  assign wr_drop     = mem_wr_en & wr_bad;
  assign wr_idx      = mem_wr_addr[WIDX_W+1:2];

  // With a single-cycle latency the line returns at the accepting edge,
  // so the request address bypasses the tag register.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    ret_fire   = 1'b0;
    ret_tag    = rd_tag;
    case (state)
      ST_IDLE: begin
        if (mem_rd_en) begin
          accept   = 1'b1;
          cnt_next = CNT_W'(READ_LAT - 1);
          if (READ_LAT == 1) begin
            ret_fire = 1'b1;
            ret_tag  = rd_tag_in;
          end else begin
            state_next = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt == '0) begin
          ret_fire   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rd_tag <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) rd_tag <= rd_tag_in;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < 4; j++) begin
      if (wr_commit && lane_en[j]) ram[j][wr_idx] <= lane_data[j*LANE_W +: LANE_W];
    end
  end

  assign ret_in_range = ~|ret_tag[TAG_W-1:LIDX_W];

  // The array read sees pre-edge contents, so a store committing on the
  // returning edge is overlaid here lane by lane.
  always_comb begin
    logic [OFF_W-3:0]  w_lo;
    logic [WIDX_W-1:0] idx;
    line_merged = '0;
    w_lo        = '0;
    idx         = '0;
    for (int unsigned w = 0; w < LINE_WORDS; w++) begin
      w_lo = (OFF_W-2)'(w);
      idx  = {ret_tag[LIDX_W-1:0], w_lo};
      for (int unsigned j = 0; j < 4; j++) begin
        line_merged[w*DATA_W + j*LANE_W +: LANE_W] = ret_in_range ? ram[j][idx] : '0;
        if (wr_commit && lane_en[j] && (mem_wr_addr[ADDR_W-1:OFF_W] == ret_tag) &&
            (mem_wr_addr[OFF_W-1:2] == w_lo)) begin
          line_merged[w*DATA_W + j*LANE_W +: LANE_W] = lane_data[j*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_data  <= {LINE_W{LINE_RST_BIT}};
      mem_rd_valid <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      mem_rd_valid <= ret_fire;
      mem_err      <= wr_drop | (ret_fire & ~ret_in_range);
      if (ret_fire) mem_rd_data <= line_merged;
    end
  end

endmodule
